// File: rtl/reg_bank_32.sv
// Register bank for the 32-bit ALU datapath.
//   - Two registered read ports (operands A and B) with a one-cycle latency and
//     an op_valid strobe marking the cycle after a read was launched.
//   - One write port for ALU write-back, committed on the rising clock edge.
//   - ZERO_REG=1 makes register 0 a hard-wired zero (writes dropped).
// Optional feature, selected at compile time by the macro WRITE_BYPASS_EN:
//   defined   -> a read launched in the same cycle as a write to the same
//                register returns the new value (write-then-read ordering).
//   undefined -> the same read returns the old contents (read-then-write).

module reg_bank_32 #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              op_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  // Architectural register file.
  logic [DATA_W-1:0] regs [NREG];

  // Write that actually changes state (writes to a hard-wired zero are dropped).
  logic              wr_commit;

  // Operand values as seen at the launching edge, before being registered.
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // True when the address names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Qualify the write strobe against the zero register.
  always_comb begin
    wr_commit = wr_en && !is_zero_reg(wr_addr);
  end

  // Select operand sources: array contents, optional same-cycle bypass, then
  // zero-register forcing, which always takes precedence over the bypass.
  // NOTE: every variable assigned here gets a value on the first lines of the
  // block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_a = regs[rs_addr];
    rd_b = regs[rt_addr];
`ifdef WRITE_BYPASS_EN
    if (wr_commit && (wr_addr == rs_addr)) rd_a = wr_data;
    if (wr_commit && (wr_addr == rt_addr)) rd_b = wr_data;
`else
`endif
    if (is_zero_reg(rs_addr)) rd_a = '0;
    if (is_zero_reg(rt_addr)) rd_b = '0;
  end

  // Register file update, operand registers and valid strobe; reset dominates.
  // NOTE: the register array is cleared on reset because a read straight after
  // reset must return zero; this forces flops rather than a RAM macro, which is
  // acceptable at 16 entries.
  // NOTE: all state here uses non-blocking assignments so the read of regs
  // feeding rd_a/rd_b sees the pre-edge contents regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      A        <= '0;
      B        <= '0;
      op_valid <= 1'b0;
    end else begin
      if (wr_commit) begin
        regs[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        A <= rd_a;
        B <= rd_b;
      end
      op_valid <= rd_en;
    end
  end

endmodule
